// File: rtl/ahb_to_wishbone.sv
// AHB-Lite slave to Wishbone classic master bridge with alignment checks and bus timeout.
// Optional feature macro AHB2WB_RMW_EN: sub-word writes are merged via read-modify-write.
module ahb_to_wishbone #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        core_cyc,
  output logic        core_stb,
  output logic        core_we,
  output logic [31:0] core_addr,
  output logic [31:0] core_data_out,
  input  logic [31:0] core_data_in,
  input  logic        core_ack
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_WR,
`ifdef AHB2WB_RMW_EN
    S_RMW_RD,
    S_RMW_GAP,
    S_RMW_WR,
`endif
    S_RESP,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                state_q;
  logic [31:0]           hrdata_q;
  logic                  hready_q;
  logic                  hresp_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           dout_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  accept;
  logic                  chk_err;
  logic                  timeout_hit;
  logic                  unused_htrans0;

  assign unused_htrans0 = htrans[0];

`ifdef AHB2WB_RMW_EN
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] mask;
  logic [31:0] merge_d;

  always_comb begin
    mask    = (size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask    = mask << {off_q, 3'b000};
    merge_d = (core_data_in & ~mask) | (hwdata & mask);
  end
`endif

  always_comb begin
    accept  = hready_q && htrans[1];
    chk_err = 1'b0;
    if (hsize > 3'd2) begin
      chk_err = 1'b1;
    end else if ((hsize == 3'd1) && haddr[0]) begin
      chk_err = 1'b1;
    end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
      chk_err = 1'b1;
`ifndef AHB2WB_RMW_EN
    end else if (hwrite && (hsize != 3'd2)) begin
      chk_err = 1'b1;
`endif
    end
    timeout_hit = TO_EN && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hrdata_q <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
`ifdef AHB2WB_RMW_EN
      size_q   <= '0;
      off_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_RESP, S_ERR2: begin
          if (accept) begin
            addr_q   <= {haddr[31:2], 2'b00};
            hready_q <= 1'b0;
            cnt_q    <= '0;
`ifdef AHB2WB_RMW_EN
            size_q   <= hsize[1:0];
            off_q    <= haddr[1:0];
`endif
            if (chk_err) begin
              state_q <= S_ERR1;
              hresp_q <= 1'b1;
              we_q    <= 1'b0;
            end else begin
              hresp_q <= 1'b0;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              if (!hwrite) begin
                state_q <= S_RD;
                we_q    <= 1'b0;
`ifdef AHB2WB_RMW_EN
              end else if (hsize != 3'd2) begin
                state_q <= S_RMW_RD;
                we_q    <= 1'b0;
`endif
              end else begin
                state_q <= S_WR;
                we_q    <= 1'b1;
              end
            end
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end

        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end

`ifdef AHB2WB_RMW_EN
        S_RMW_GAP: begin
          state_q <= S_RMW_WR;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          cnt_q   <= '0;
        end
`endif

        // Remaining states all drive stb; an ack in the limit cycle beats the timeout.
        default: begin
          if (core_ack) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (state_q == S_RD) begin
              hrdata_q <= core_data_in;
            end
`ifdef AHB2WB_RMW_EN
            if (state_q == S_RMW_RD) begin
              state_q <= S_RMW_GAP;
              dout_q  <= merge_d;
            end else begin
              state_q  <= S_RESP;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
`else
            state_q  <= S_RESP;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
`endif
          end else if (timeout_hit) begin
            state_q <= S_ERR1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            hresp_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign hrdata        = hrdata_q;
  assign hready        = hready_q;
  assign hresp         = hresp_q;
  assign core_cyc      = cyc_q;
  assign core_stb      = stb_q;
  assign core_we       = we_q;
  assign core_addr     = addr_q;
  assign core_data_out = (state_q == S_WR) ? hwdata : dout_q;

endmodule

// File: tb/tb_ahb_to_wishbone.sv
// Randomized bench for ahb_to_wishbone: AHB master driver, Wishbone memory slave and transfer-level reference model.
module tb_ahb_to_wishbone;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        core_cyc;
  logic        core_stb;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in;
  logic        core_ack;

  ahb_to_wishbone #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_addr(core_addr),
    .core_data_out(core_data_out), .core_data_in(core_data_in), .core_ack(core_ack)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cycle_no = 0;
  int unsigned stb_start = 0;
  int unsigned sl_lat = 0;
  int unsigned sl_wait = 0;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle_no++;

  // Wishbone memory slave: acks after sl_lat wait cycles, random ack noise while stb is low.
  always @(negedge clk) begin
    if (core_cyc && core_stb) begin
      if (sl_wait >= sl_lat) begin
        core_ack     = 1'b1;
        core_data_in = mem[core_addr[7:2]];
      end else begin
        core_ack     = 1'b0;
        core_data_in = $urandom;
        sl_wait++;
      end
    end else begin
      core_ack     = 1'($urandom_range(0, 1));
      core_data_in = $urandom;
      sl_wait      = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && core_cyc && core_stb && core_ack && core_we) begin
      wlog_addr.push_back(core_addr);
      wlog_data.push_back(core_data_out);
      mem[core_addr[7:2]] = core_data_out;
    end
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      htrans = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      haddr  = $urandom;
      hwrite = 1'($urandom);
      @(negedge clk);
      check_eq("idle_bus", {28'd0, hready, hresp, core_cyc, core_stb}, 32'b1000);
    end
  endtask

  // Called at a negedge with hready=1; returns at the negedge where hready is next 1.
  task automatic do_xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd, input int unsigned lat);
    bit          err, rmw, tmo, seen;
    int unsigned exp_lat, exp_cyc, cycles, ncyc, bad, nerr1, idx, nw;
    logic        first_we, last_we;
    logic [31:0] exp_w;

    err = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`ifndef AHB2WB_RMW_EN
    if (wr && sz != 3'd2) err = 1'b1;
`endif
    rmw = !err && wr && (sz != 3'd2);
    tmo = !err && (lat >= TO);
    idx = 32'(a[7:2]);
    if (err) begin
      exp_lat = 2; exp_cyc = 0;
    end else if (tmo) begin
      exp_lat = TO + 2; exp_cyc = TO;
    end else begin
      exp_cyc = (rmw ? 2 : 1) * (lat + 1);
      exp_lat = exp_cyc + (rmw ? 2 : 1);
    end

    haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; hwdata = wd; sl_lat = lat;
    cycles = 0; ncyc = 0; bad = 0; nerr1 = 0; seen = 0; first_we = 0; last_we = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (core_cyc) begin
        if (!seen) begin
          first_we  = core_we;
          stb_start = cycle_no;
          seen      = 1;
        end
        last_we = core_we;
        ncyc++;
        if (core_stb !== 1'b1 || core_addr !== {a[31:2], 2'b00}) bad++;
      end else if (core_stb) begin
        bad++;
      end
      if (!hready && hresp) nerr1++;
      if (cycles == 1) begin
        htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
      end
    end while (!hready && cycles < 200);

    check_eq("latency", cycles, exp_lat);
    check_eq("hresp", {31'd0, hresp}, {31'd0, err || tmo});
    check_eq("cyc_cycles", ncyc, exp_cyc);
    check_eq("bus_bad", bad, 0);
    check_eq("err1_cycles", nerr1, (err || tmo) ? 1 : 0);
    if (!err) begin
      check_eq("first_we", {31'd0, first_we}, {31'd0, wr && !rmw});
      check_eq("last_we", {31'd0, last_we}, {31'd0, wr && !(rmw && tmo)});
    end
    if (!err && !tmo && !wr) check_eq("hrdata", hrdata, ref_mem[idx]);

    nw = (!err && !tmo && wr) ? 1 : 0;
    check_eq("wb_writes", wlog_addr.size(), nw);
    if (nw == 1 && wlog_addr.size() == 1) begin
      exp_w = wd;
      if (rmw) begin
        exp_w = ref_mem[idx];
        for (int unsigned b = 32'(a[1:0]); b < 32'(a[1:0]) + (32'd1 << sz); b++)
          exp_w[8*b +: 8] = wd[8*b +: 8];
      end
      ref_mem[idx] = exp_w;
      check_eq("wb_addr", wlog_addr[0], {a[31:2], 2'b00});
      check_eq("wb_data", wlog_data[0], exp_w);
    end
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  initial begin
    int unsigned t1;
    int unsigned lat_tab [7] = '{0, 0, 1, 2, 3, TO - 1, TO + 5};
    logic [31:0] a;
    logic [2:0]  sz;

    rst = 1'b1; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0; hwdata = '0;
    core_ack = 1'b0; core_data_in = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
    mem[0]  = 32'h1122_3344; ref_mem[0]  = 32'h1122_3344;

    repeat (2) @(negedge clk);
    check_eq("rst_ahb", {30'd0, hready, hresp}, 32'b10);
    check_eq("rst_hrdata", hrdata, 32'h0);
    check_eq("rst_wb", {29'd0, core_cyc, core_stb, core_we}, 32'h0);
    check_eq("rst_addr", core_addr, 32'h0);
    check_eq("rst_dout", core_data_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_xfer(32'h0000_0040, 1'b0, 3'd2, 32'h0, 3);
    check_eq("read_deadbeef", hrdata, 32'hDEAD_BEEF);
    do_xfer(32'h0000_0103, 1'b1, 3'd0, 32'hA5A5_A5A5, 0);
`ifdef AHB2WB_RMW_EN
    check_eq("rmw_word", mem[0], 32'hA522_3344);
`endif
    do_xfer(32'h0000_0101, 1'b1, 3'd1, $urandom, 0);
    do_xfer(32'h0000_0104, 1'b1, 3'd0, $urandom, 0);
    do_xfer(32'h0000_0080, 1'b0, 3'd2, 32'h0, 1000);
    do_xfer(32'h0000_0084, 1'b0, 3'd2, 32'h0, 0);
    do_xfer(32'h0000_0088, 1'b1, 3'd2, $urandom, 0);
    t1 = stb_start;
    do_xfer(32'h0000_0088, 1'b0, 3'd2, 32'h0, 0);
    check_eq("b2b_stb_gap", stb_start - t1, 2);
    do_xfer(32'h0000_008C, 1'b0, 3'd2, 32'h0, TO - 1);
    do_xfer(32'h0000_0090, 1'b1, 3'd2, $urandom, TO);
    idle(2);

`ifdef AHB2WB_RMW_EN
    haddr = 32'h20; hwrite = 1'b1; hsize = 3'd0;
`else
    haddr = 32'h20; hwrite = 1'b0; hsize = 3'd2;
`endif
    htrans = 2'b10; hwdata = $urandom; sl_lat = 1000;
    @(negedge clk);
    htrans = 2'b00;
    check_eq("rst_mid_stb", {31'd0, core_stb}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_bus", {28'd0, core_cyc, core_stb, hready, hresp}, 32'b0010);
    rst = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
    do_xfer(32'h0000_0024, 1'b0, 3'd2, 32'h0, 1);

    for (int unsigned n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 3'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 3'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_xfer(a, 1'($urandom), sz, $urandom, lat_tab[$urandom_range(0, 6)]);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
